// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding
// and default widths.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        RDRAIN = 2'd3
    } state_e;

    localparam int DEF_DWIDTH     = 16;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 8;

endpackage

// File: rtl/mem_access_ctrl.sv
// Burst controller between the core and the single-port data RAM: one
// load or store burst at a time, auto-incrementing address, registered load data.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [DWIDTH-1:0]     wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    output logic [DWIDTH-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  rdata_last,
    input  logic                  rdata_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0]     ram_data,
    output logic                  ram_we,
    input  logic [DWIDTH-1:0]     ram_dout,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [DWIDTH-1:0]     rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  rdata_last_q, rdata_last_d;
    logic                  capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

    // The output register may load a new beat whenever it is empty or the
    // core is taking the current one, so back-to-back beats need no bubble.
    assign capture = !rdata_valid_q || rdata_ready;

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        rdata_last_d  = rdata_last_q;
        req_ready     = 1'b0;
        wdata_ready   = 1'b0;
        ram_we        = 1'b0;
        ram_data      = '0;
        ram_addr      = cur_addr_q;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cur_addr_d  = req_addr;
                    remaining_d = req_len;
                    state_d     = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                ram_data    = wdata;
                ram_we      = wdata_valid;
                if (wdata_valid) begin
                    cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                    end
                end
            end
            READ: begin
                if (capture) begin
                    rdata_d       = ram_dout;
                    rdata_valid_d = 1'b1;
                    rdata_last_d  = (remaining_q == '0);
                    cur_addr_d    = cur_addr_q + ADDR_WIDTH'(1);
                    if (remaining_q == '0) begin
                        state_d = RDRAIN;
                    end else begin
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                    end
                end
            end
            RDRAIN: begin
                if (rdata_valid_q && rdata_ready) begin
                    rdata_valid_d = 1'b0;
                    rdata_last_d  = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a RAM model plus a transaction-level
// reference (expected write and read-beat queues) checked every cycle.
module tb_mem_access_ctrl;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } rd_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic [15:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        rdata_last;
    logic        rdata_ready;
    logic [15:0] ram_addr;
    logic [15:0] ram_data;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic        busy;

    logic [15:0] ram    [0:65535];
    logic [15:0] refMem [0:65535];

    wr_t expWrites[$];
    rd_t expReads[$];
    int  vectors    = 0;
    int  miscompares = 0;
    int  writeCount = 0;
    int  readsDone  = 0;

    mem_access_ctrl #(
        .DWIDTH    (16),
        .ADDR_WIDTH(16),
        .LEN_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wdata      (wdata),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .rdata_last (rdata_last),
        .rdata_ready(rdata_ready),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: combinational read, write on the rising edge.
    assign ram_dout = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flagFailure(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got event, expected none at %0t", name, $time);
    endtask

    // Compare process: every RAM write and every consumed load beat must
    // match the front of the reference queues.
    always @(negedge clk) begin
        if (rst_n) begin
            wr_t w;
            rd_t r;
            checkOutput("req_ready_vs_busy", {31'd0, req_ready}, {31'd0, !busy});
            checkOutput("ram_we_gating", {31'd0, ram_we}, {31'd0, wdata_valid && wdata_ready});
            if (ram_we) begin
                writeCount++;
                if (expWrites.size() == 0) begin
                    flagFailure("unexpected_write");
                end else begin
                    w = expWrites.pop_front();
                    checkOutput("wr_addr", {16'd0, ram_addr}, {16'd0, w.addr});
                    checkOutput("wr_data", {16'd0, ram_data}, {16'd0, w.data});
                end
            end
            if (rdata_valid && rdata_ready) begin
                readsDone++;
                if (expReads.size() == 0) begin
                    flagFailure("unexpected_read_beat");
                end else begin
                    r = expReads.pop_front();
                    checkOutput("rd_data", {16'd0, rdata}, {16'd0, r.data});
                    checkOutput("rd_last", {31'd0, rdata_last}, {31'd0, r.last});
                end
            end
        end
    end

    task automatic issueReq(input logic we, input logic [15:0] addr, input logic [7:0] len);
        int k;
        for (k = 0; k < 50 && !req_ready; k++) begin
            @(posedge clk);
            #1;
        end
        if (!req_ready) flagFailure("req_ready_timeout");
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic applyStimulus_store(input logic [15:0] addr, input int len,
                                       input logic [15:0] base, input logic [7:0] pat, input int plen);
        int beat = 0;
        int cyc = 0;
        int w0;
        for (int i = 0; i <= len; i++) begin
            wr_t w;
            w.addr = 16'(addr + i);
            w.data = 16'(base + i);
            expWrites.push_back(w);
            refMem[w.addr] = w.data;
        end
        w0 = writeCount;
        issueReq(1'b1, addr, 8'(len));
        while (beat <= len && cyc < 2000) begin
            wdata_valid = pat[cyc % plen];
            wdata       = 16'(base + beat);
            if (wdata_valid) beat++;
            @(posedge clk);
            #1;
            cyc++;
        end
        wdata_valid = 1'b0;
        if (cyc >= 2000) flagFailure("store_timeout");
        checkOutput("store_done_idle", {31'd0, busy}, 32'd0);
        checkOutput("store_write_count", 32'(writeCount - w0), 32'(len + 1));
    endtask

    task automatic applyStimulus_load(input logic [15:0] addr, input int len, input logic [7:0] pat,
                                      input int plen, input logic [15:0] expFirst);
        int cyc = 0;
        int target;
        for (int i = 0; i <= len; i++) begin
            rd_t r;
            r.data = refMem[16'(addr + i)];
            r.last = (i == len);
            expReads.push_back(r);
        end
        target = readsDone + len + 1;
        issueReq(1'b0, addr, 8'(len));
        while (cyc < 3000) begin
            rdata_ready = pat[cyc % plen];
            if (cyc == 0) begin
                checkOutput("load_lat_c1_valid", {31'd0, rdata_valid}, 32'd0);
                checkOutput("load_lat_c1_addr", {16'd0, ram_addr}, {16'd0, addr});
            end
            if (cyc == 1) begin
                checkOutput("load_lat_c2_valid", {31'd0, rdata_valid}, 32'd1);
                checkOutput("load_first_data", {16'd0, rdata}, {16'd0, expFirst});
            end
            @(posedge clk);
            #1;
            cyc++;
            if (readsDone >= target) break;
        end
        rdata_ready = 1'b0;
        if (cyc >= 3000) flagFailure("load_timeout");
        checkOutput("load_done_idle", {31'd0, busy}, 32'd0);
        checkOutput("load_done_valid", {31'd0, rdata_valid}, 32'd0);
    endtask

    initial begin
        int r0;
        int k;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        wdata       = '0;
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;

        #3;
        checkOutput("rst_ram_we", {31'd0, ram_we}, 32'd0);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        checkOutput("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        checkOutput("rst_ram_data", {16'd0, ram_data}, 32'd0);
        checkOutput("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_rdata_last", {31'd0, rdata_last}, 32'd0);

        $display("[TB] store burst 0x0010 len 3");
        applyStimulus_store(16'h0010, 3, 16'hA000, 8'hFF, 1);
        checkOutput("ram_0010", {16'd0, ram[16'h0010]}, 32'hA000);
        checkOutput("ram_0013", {16'd0, ram[16'h0013]}, 32'hA003);

        $display("[TB] load burst 0x0010 len 3, ready held");
        applyStimulus_load(16'h0010, 3, 8'h01, 1, 16'hA000);

        $display("[TB] load burst 0x0010 len 2, ready toggling");
        applyStimulus_load(16'h0010, 2, 8'b1001, 4, 16'hA000);

        $display("[TB] store burst wrapping at 0xFFFE with bubbles");
        applyStimulus_store(16'hFFFE, 3, 16'hB000, 8'b1101, 4);
        checkOutput("ram_fffe", {16'd0, ram[16'hFFFE]}, 32'hB000);
        checkOutput("ram_0000", {16'd0, ram[16'h0000]}, 32'hB002);
        checkOutput("ram_0001", {16'd0, ram[16'h0001]}, 32'hB003);
        applyStimulus_load(16'hFFFE, 3, 8'b0111, 3, 16'hB000);

        $display("[TB] single-beat bursts");
        applyStimulus_store(16'h0200, 0, 16'hC000, 8'hFF, 1);
        applyStimulus_load(16'h0200, 0, 8'h01, 1, 16'hC000);

        $display("[TB] maximum-length bursts");
        applyStimulus_store(16'h1000, 255, 16'hD000, 8'hFF, 1);
        checkOutput("ram_10ff", {16'd0, ram[16'h10FF]}, 32'hD0FF);
        applyStimulus_load(16'h1000, 255, 8'h01, 1, 16'hD000);

        $display("[TB] reset mid-load");
        for (int i = 0; i <= 3; i++) begin
            rd_t r;
            r.data = refMem[16'(16'h0010 + i)];
            r.last = (i == 3);
            expReads.push_back(r);
        end
        r0 = readsDone;
        issueReq(1'b0, 16'h0010, 8'd3);
        rdata_ready = 1'b1;
        for (k = 0; k < 20 && readsDone == r0; k++) begin
            @(posedge clk);
            #1;
        end
        if (readsDone == r0) flagFailure("reset_test_first_beat_timeout");
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        expReads.delete();
        rdata_ready = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus_load(16'h0010, 3, 8'h01, 1, 16'hA000);

        checkOutput("writes_drained", 32'(expWrites.size()), 32'd0);
        checkOutput("reads_drained", 32'(expReads.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller that drives the single-port data RAM: addr/data/we out, combinational dout back.
- Accepts load and store burst requests from the core over a valid/ready handshake.
- Streams store data from the core into the RAM and load data from the RAM back to the core.
- Auto-increments the address and counts beats per burst; one burst in flight at a time.

Parameters:
- DWIDTH, 16, RAM data width in bits.
- ADDR_WIDTH, 16, RAM address width in bits.
- LEN_WIDTH, 8, burst length field width; a burst carries req_len+1 beats (1..2^LEN_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  burst request valid.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_we  input  1  1 = store burst, 0 = load burst.
- req_addr  input  ADDR_WIDTH  burst base address.
- req_len  input  LEN_WIDTH  beats minus one.
- wdata  input  DWIDTH  store data beat.
- wdata_valid  input  1  store beat valid.
- wdata_ready  output  1  store beat accepted.
- rdata  output  DWIDTH  load data beat (registered).
- rdata_valid  output  1  load beat valid.
- rdata_last  output  1  marks the final load beat.
- rdata_ready  input  1  core accepts load beat.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_data  output  DWIDTH  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_dout  input  DWIDTH  RAM read data; combinational, valid the same cycle when ram_we=0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low on rst_n; all registers clear immediately when rst_n=0.
- Reset values: state=IDLE, cur_addr=0, remaining=0, rdata=0, rdata_valid=0, rdata_last=0. Outputs after reset: ram_we=0, ram_addr=0, ram_data=0, wdata_ready=0, req_ready=1, busy=0.
- States: IDLE, WRITE, READ, RDRAIN.
- IDLE:
  - req_ready=1; ram_we=0; ram_addr=cur_addr.
  - On req_valid: latch cur_addr=req_addr and remaining=req_len.
  - Go to WRITE if req_we, else READ.
- WRITE:
  - wdata_ready=1; ram_addr=cur_addr; ram_data=wdata; ram_we=wdata_valid (combinational; the RAM samples on the next rising edge).
  - On each wdata_valid beat: cur_addr+1. If remaining==0, go to IDLE; else remaining-1.
  - Throughput 1 beat/cycle. wdata_valid low inserts bubbles with no write.
  - In all other states ram_we=0 and wdata_ready=0.
- READ:
  - ram_we=0; ram_addr=cur_addr.
  - Capture condition: !rdata_valid || rdata_ready.
  - On capture: rdata=ram_dout, rdata_valid=1, rdata_last=(remaining==0), cur_addr+1.
  - After a capture with remaining==0, go to RDRAIN; otherwise remaining-1.
  - When the capture condition is false, hold rdata, rdata_valid and rdata_last stable.
- RDRAIN: on rdata_valid && rdata_ready, clear rdata_valid and rdata_last and go to IDLE.
- Read latency:
  - Request handshake in cycle 0, ram_addr=base in cycle 1, first rdata_valid in cycle 2.
  - Then 1 beat/cycle while rdata_ready=1.
- Address arithmetic: cur_addr increments modulo 2^ADDR_WIDTH, so 0xFFFF+1 wraps to 0x0000 with no error.
- Length arithmetic: req_len=0 gives a single beat; req_len=2^LEN_WIDTH-1 gives the maximum burst.
- Simultaneous events:
  - A req_valid asserted in any non-IDLE state is ignored until IDLE (req_ready=0).
  - A capture and a consume in the same READ cycle replace rdata with no bubble.
- Reset mid-burst:
  - The burst is abandoned; beats already written stay in the RAM.
  - rdata_valid drops immediately (asynchronous).
  - No response is owed after reset.

Decomposition:
- Shared package mem_access_pkg holds the state encodings (IDLE=2'd0, WRITE=2'd1, READ=2'd2, RDRAIN=2'd3) and the default width constants.
- No sub-module; the FSM, counters and output register all live in mem_access_ctrl, which instantiates nothing. Integration pairs it with the data RAM at the top level.

Test Plan:
- Reset then idle -> ram_we=0, req_ready=1, busy=0, rdata_valid=0.
- Store burst: addr=0x0010, len=3, wdata 0xA000..0xA003 with continuous valid -> ram_we high 4 consecutive cycles at 0x0010..0x0013, then IDLE.
- Load burst of the same region with rdata_ready=1 -> rdata_valid 2 cycles after the request, data 0xA000..0xA003, rdata_last on the 4th beat only.
- Load len=2 with rdata_ready toggling 1,0,0,1,... -> rdata holds during stalls, no beat lost or duplicated, address advances only on capture.
- Wrap: store addr=0xFFFE, len=3 -> writes land at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst_n pulsed low mid-load after beat 1 -> rdata_valid=0 and state=IDLE immediately; a new request is accepted and completes correctly.
